default_iter_core: RTL

//  Iterative, parametrised DEFAULT block-cipher engine; successor to the fixed, free-running Default_Top.

---
 rtl/default_pkg.sv | 65 ++++++
 rtl/default_round.sv | 65 ++++++
 rtl/default_iter_core.sv | 136 +++++++++++++
 3 files changed

// File: rtl/default_pkg.sv
// Shared tables and helpers for the iterative DEFAULT cipher engine:
// S-boxes, bit permutation, key-schedule nibble mix and FSM encoding.
package default_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAYER_SB [16] = '{
      4'h0, 4'h3, 4'h7, 4'hE, 4'hD, 4'h4, 4'hA, 4'h9,
      4'hC, 4'hF, 4'h1, 4'h8, 4'hB, 4'h2, 4'h6, 4'h5
   };

   localparam logic [3:0] LAYER_SB_INV [16] = '{
      4'h0, 4'hA, 4'hD, 4'h1, 4'h5, 4'hF, 4'hE, 4'h2,
      4'hB, 4'h7, 4'h6, 4'hC, 4'h8, 4'h4, 4'h3, 4'h9
   };

   localparam logic [3:0] CORE_SB [16] = '{
      4'h1, 4'h9, 4'h6, 4'hF, 4'h7, 4'hC, 4'h8, 4'h2,
      4'hA, 4'hE, 4'hD, 4'h0, 4'h4, 4'h3, 4'hB, 4'h5
   };

   localparam logic [3:0] CORE_SB_INV [16] = '{
      4'hB, 4'h0, 4'h7, 4'hD, 4'hC, 4'hF, 4'h2, 4'h4,
      4'h6, 4'h1, 4'h8, 4'hE, 4'h5, 4'hA, 4'h9, 4'h3
   };

   function automatic logic [3:0] sb_layer(input logic [3:0] x);
      return LAYER_SB[x];
   endfunction

   function automatic logic [3:0] sb_layer_inv(input logic [3:0] x);
      return LAYER_SB_INV[x];
   endfunction

   function automatic logic [3:0] sb_core(input logic [3:0] x);
      return CORE_SB[x];
   endfunction

   function automatic logic [3:0] sb_core_inv(input logic [3:0] x);
      return CORE_SB_INV[x];
   endfunction

   // Bit i moves to i*(w/4) mod (w-1); w/4 is coprime to w-1 for any w.
   function automatic int perm_idx(input int i, input int w);
      return (i == w - 1) ? i : (i * (w / 4)) % (w - 1);
   endfunction

   function automatic int perm_inv_idx(input int i, input int w);
      return (i == w - 1) ? i : (i * 4) % (w - 1);
   endfunction

   // Key update: rotate left one nibble, then mix the wrapped nibble.
   function automatic logic [3:0] key_mix(input logic [3:0] x);
      return sb_core(x);
   endfunction

   function automatic logic [3:0] key_mix_inv(input logic [3:0] x);
      return sb_core_inv(x);
   endfunction

endpackage

// File: rtl/default_round.sv
// One combinational DEFAULT round, forward or inverse, with the
// matching single-step key-schedule advance.
module default_round
   import default_pkg::*;
#(
   parameter int W = 128
) (
   input  logic [W-1:0] i_state,
   input  logic [W-1:0] i_rk,
   input  logic         i_core_sel,
   input  logic         i_inv,
   output logic [W-1:0] o_state,
   output logic [W-1:0] o_rk
);

   localparam int NIB = W / 4;

   logic [W-1:0] w_rk_next;
   logic [W-1:0] w_rk_prev;
   logic [W-1:0] w_sub;
   logic [W-1:0] w_perm;
   logic [W-1:0] w_x;
   logic [W-1:0] w_pinv;
   logic [W-1:0] w_dec;

   assign w_rk_next = {i_rk[W-5:0], key_mix(i_rk[W-1:W-4])};
   assign w_rk_prev = {key_mix_inv(i_rk[3:0]), i_rk[W-1:4]};

   always_comb begin
      w_sub = '0;
      for (int n = 0; n < NIB; n++) begin
         w_sub[n*4 +: 4] = i_core_sel ? sb_core(i_state[n*4 +: 4])
                                      : sb_layer(i_state[n*4 +: 4]);
      end
   end

   always_comb begin
      w_perm = '0;
      for (int i = 0; i < W; i++) begin
         w_perm[perm_idx(i, W)] = w_sub[i];
      end
   end

   // Inverse round peels the key first, so it needs the previous round key.
   assign w_x = i_state ^ w_rk_prev;

   always_comb begin
      w_pinv = '0;
      for (int i = 0; i < W; i++) begin
         w_pinv[perm_inv_idx(i, W)] = w_x[i];
      end
   end

   always_comb begin
      w_dec = '0;
      for (int n = 0; n < NIB; n++) begin
         w_dec[n*4 +: 4] = i_core_sel ? sb_core_inv(w_pinv[n*4 +: 4])
                                      : sb_layer_inv(w_pinv[n*4 +: 4]);
      end
   end

   assign o_state = i_inv ? w_dec : (w_perm ^ i_rk);
   assign o_rk    = i_inv ? w_rk_prev : w_rk_next;

endmodule

// File: rtl/default_iter_core.sv
// Iterative DEFAULT cipher engine: valid/ready in and out, encrypt or
// decrypt, RPC rounds per clock, IDLE/RUN/DONE control.
module default_iter_core
   import default_pkg::*;
#(
   parameter int BLOCK_W      = 128,
   parameter int LAYER_ROUNDS = 28,
   parameter int CORE_ROUNDS  = 24,
   parameter int RPC          = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [BLOCK_W-1:0] plain,
   input  logic [BLOCK_W-1:0] key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] cipher,
   output logic               busy
);

   localparam int TOTAL = 2 * LAYER_ROUNDS + CORE_ROUNDS;
   localparam int CW    = $clog2(TOTAL + 1);

   localparam logic [CW-1:0] C_RPC   = CW'(RPC);
   localparam logic [CW-1:0] C_TOTAL = CW'(TOTAL);
   localparam logic [CW-1:0] C_LO    = CW'(LAYER_ROUNDS);
   localparam logic [CW-1:0] C_HI    = CW'(LAYER_ROUNDS + CORE_ROUNDS);

   if (BLOCK_W % 4 != 0 || BLOCK_W < 8) begin : g_bad_width
      $error("BLOCK_W must be a multiple of 4 and at least 8");
   end
   if (RPC < 1) begin : g_bad_rpc
      $error("RPC must be at least 1");
   end else if (LAYER_ROUNDS % RPC != 0 || CORE_ROUNDS % RPC != 0) begin : g_bad_div
      $error("RPC must divide LAYER_ROUNDS and CORE_ROUNDS");
   end

   state_t r_state;
   state_t w_next;

   logic               r_in_ready;
   logic               r_mode;
   logic [CW-1:0]      r_cnt;
   logic [BLOCK_W-1:0] r_data;
   logic [BLOCK_W-1:0] r_rk;
   logic [BLOCK_W-1:0] r_cipher;

   logic               w_accept;
   logic               w_last;
   logic               w_core;
   logic [BLOCK_W-1:0] w_key0;
   logic [BLOCK_W-1:0] w_st [RPC+1];
   logic [BLOCK_W-1:0] w_rk [RPC+1];

   function automatic logic [BLOCK_W-1:0] key_adv(
      input logic [BLOCK_W-1:0] k
   );
      logic [BLOCK_W-1:0] t;
      t = k;
      for (int n = 0; n < TOTAL; n++) begin
         t = {t[BLOCK_W-5:0], key_mix(t[BLOCK_W-1:BLOCK_W-4])};
      end
      return t;
   endfunction

   assign w_accept = in_valid & r_in_ready;
   assign w_last   = (r_cnt + C_RPC) == C_TOTAL;
   // RPC divides both phase lengths, so a clock never straddles a boundary.
   assign w_core   = (r_cnt >= C_LO) && (r_cnt < C_HI);
   assign w_key0   = mode ? key_adv(key) : key;

   assign w_st[0] = r_data;
   assign w_rk[0] = r_rk;

   for (genvar g = 0; g < RPC; g++) begin : g_rounds
      default_round #(
         .W (BLOCK_W)
      ) u_round (
         .i_state    (w_st[g]),
         .i_rk       (w_rk[g]),
         .i_core_sel (w_core),
         .i_inv      (r_mode),
         .o_state    (w_st[g+1]),
         .o_rk       (w_rk[g+1])
      );
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept)  w_next = RUN;
         RUN:     if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next == IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode   <= 1'b0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_rk     <= '0;
         r_cipher <= '0;
      end else if (w_accept) begin
         r_mode <= mode;
         r_cnt  <= '0;
         r_data <= plain;
         r_rk   <= w_key0;
      end else if (r_state == RUN) begin
         r_data <= w_st[RPC];
         r_rk   <= w_rk[RPC];
         r_cnt  <= r_cnt + C_RPC;
         if (w_last) r_cipher <= w_st[RPC];
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN);
   assign cipher    = r_cipher;

endmodule
